bist_response_analyzer: RTL

- Response side of the BIST loop; consumes the controller's init/running/finish strobes together with the circuit-under-test response word.
- Compacts responses into a multiple-input signature register (MISR) and counts compacted cycles.
- At finish, compares signature and cycle count against run-time expected values and raises a held done with a pass/fail verdict.
- Sits between the CUT outputs and the top-level BIST status register.

---
 rtl/bist_response_analyzer_if.sv | 41 ++++
 rtl/bist_response_analyzer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer_if.sv
// ---------------------------------------------------------------------------
// bist_response_analyzer_if
// Bundles the controller strobes, CUT response, run-time expectations and the
// analyzer status outputs into one bus.
//   master : BIST controller / status side (drives strobes, data, expectations)
//   slave  : response analyzer (drives signature, cycles, busy and verdict)
// Signals:
//   init, running, finish : controller strobes
//   data_in [W]           : CUT response word
//   golden_sig [W]        : expected signature (sampled in COMPARE)
//   exp_cycles [CW]       : expected compacted-cycle count (sampled in COMPARE)
//   signature [W], cycles [CW], busy, done, pass, fail, proto_err : status
// ---------------------------------------------------------------------------
interface bist_response_analyzer_if #(
  parameter int W  = 8,
  parameter int CW = 8
);
  logic          init;
  logic          running;
  logic          finish;
  logic [W-1:0]  data_in;
  logic [W-1:0]  golden_sig;
  logic [CW-1:0] exp_cycles;
  logic [W-1:0]  signature;
  logic [CW-1:0] cycles;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic          proto_err;

  modport master (
    output init, running, finish, data_in, golden_sig, exp_cycles,
    input  signature, cycles, busy, done, pass, fail, proto_err
  );

  modport slave (
    input  init, running, finish, data_in, golden_sig, exp_cycles,
    output signature, cycles, busy, done, pass, fail, proto_err
  );
endinterface

// File: rtl/bist_response_analyzer.sv
// ---------------------------------------------------------------------------
// bist_response_analyzer
// Response side of the BIST loop. Compacts CUT responses into a MISR while the
// controller asserts running, counts compacted cycles (saturating), and on
// finish compares signature and count with run-time expected values, raising a
// held done with a pass/fail verdict. Out-of-sequence strobes set a sticky
// proto_err that is cleared by the next init.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : bist_response_analyzer_if.slave (strobes, data, expectations,
//             signature/cycles/busy/done/pass/fail/proto_err outputs)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module bist_response_analyzer #(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(8'h1D),
  parameter logic [W-1:0] SEED = '0,
  parameter int           CW   = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  bist_response_analyzer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sig_q, sig_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          proto_err_q, proto_err_d;

  logic [W-1:0]  sig_step;
  logic          cycles_sat;
  logic          match;

  // One MISR step: shift left, fold the outgoing MSB back through the
  // polynomial taps, then mix in the whole response word.
  assign sig_step   = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ bus.data_in;
  assign cycles_sat = &cycles_q;
  assign match      = (sig_q == bus.golden_sig) && (cycles_q == bus.exp_cycles);

  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    cycles_d    = cycles_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    proto_err_d = proto_err_q;

    if (bus.init) begin
      // init wins over everything and swallows same-cycle running/finish.
      state_d     = S_ARMED;
      sig_d       = SEED;
      cycles_d    = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      proto_err_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.running || bus.finish) proto_err_d = 1'b1;
        end
        S_ARMED: begin
          // A running+finish cycle compacts first; COMPARE then sees the
          // updated signature and count.
          if (bus.running) begin
            sig_d = sig_step;
            if (!cycles_sat) cycles_d = cycles_q + 1'b1;
          end
          if (bus.finish) state_d = S_COMPARE;
        end
        S_COMPARE: begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = match;
          fail_d  = !match;
          if (bus.running || bus.finish) proto_err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // busy is registered from the next state so it lines up with state_q.
    busy_d = (state_d == S_ARMED) || (state_d == S_COMPARE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sig_q       <= SEED;
      cycles_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      cycles_q    <= cycles_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.signature = sig_q;
  assign bus.cycles    = cycles_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.proto_err = proto_err_q;

endmodule
